cpu_clock_ctrl: RTL and testbench

Run/step/halt gate for the 8-bit CPU. It sits directly downstream of the clock divider and turns the divider's slow square wave `hz_in` into single-`clk`-cycle CPU enable strobes. Strobes come from either the divided clock (run mode) or a debounced manual step button (step mode). Strobes are suppressed while the CPU has executed HLT. All CPU registers are clocked by `clk` and advance only when `cpu_en` is high.

---
 rtl/cpu_clock_ctrl_if.sv | 22 ++
 rtl/cpu_clock_ctrl.sv | 117 +++++++++++
 tb/tb_cpu_clock_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clock_ctrl_if.sv
// Handshake bundle between the clock divider/control unit and the run/step/halt gate.
interface cpu_clock_ctrl_if;
  logic       hz_in;
  logic       mode;
  logic       step_btn;
  logic       halt;
  logic       resume;
  logic       cpu_en;
  logic       halted;
  logic [1:0] state;
  logic [7:0] tick_count;

  modport master (
    output hz_in, mode, step_btn, halt, resume,
    input  cpu_en, halted, state, tick_count
  );

  modport slave (
    input  hz_in, mode, step_btn, halt, resume,
    output cpu_en, halted, state, tick_count
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt gate: turns hz_in rises or debounced step presses into one-cycle cpu_en strobes.
// Run strobe 2 clk after the first s1 sample of a rise; step strobe 1 clk after the debounced level rises.
module cpu_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  cpu_clock_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STEP   = 2'b01,
    HALTED = 2'b10
  } state_t;

  logic          hz_s1, hz_s2, hz_s3;
  logic          btn_s1, btn_s2;
  logic          db, db_q;
  logic [CW-1:0] db_cnt;
  logic          hz_rise, step_req;

  state_t        state_r;
  logic          cpu_en_r;
  logic          halted_r;
  logic [7:0]    tick_r;

  assign hz_rise  = hz_s2 & ~hz_s3;
  assign step_req = db & ~db_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_s1  <= 1'b0;
      hz_s2  <= 1'b0;
      hz_s3  <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      hz_s1  <= bus.hz_in;
      hz_s2  <= hz_s1;
      hz_s3  <= hz_s2;
      btn_s1 <= bus.step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // db follows the synchronized button only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      db_q <= db;
      if (btn_s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      cpu_en_r <= 1'b0;
      halted_r <= 1'b0;
      tick_r   <= 8'd0;
    end else begin
      cpu_en_r <= 1'b0;
      halted_r <= 1'b0;
      if (bus.halt) begin
        state_r  <= HALTED;
        halted_r <= 1'b1;
      end else begin
        case (state_r)
          HALTED: begin
            if (bus.resume) begin
              state_r <= bus.mode ? STEP : RUN;
            end else begin
              halted_r <= 1'b1;
            end
          end
          RUN: begin
            if (bus.mode) begin
              state_r <= STEP;
            end else if (hz_rise) begin
              cpu_en_r <= 1'b1;
              tick_r   <= tick_r + 8'd1;
            end
          end
          STEP: begin
            if (!bus.mode) begin
              state_r <= RUN;
            end else if (step_req) begin
              cpu_en_r <= 1'b1;
              tick_r   <= tick_r + 8'd1;
            end
          end
          default: state_r <= RUN;
        endcase
      end
    end
  end

  assign bus.cpu_en     = cpu_en_r;
  assign bus.halted     = halted_r;
  assign bus.state      = state_r;
  assign bus.tick_count = tick_r;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: event-history model plus directed scenarios with literal expectations.
module tb_cpu_clock_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_clock_ctrl_if bus();

  cpu_clock_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int pulses  = 0;

  // Model: raw input histories, one bit per clk edge, newest at index 0.
  logic [3:0]  hz_h;
  logic [15:0] btn_h;
  logic        m_db, m_db_rose;
  logic [1:0]  m_st;
  logic        m_en;
  logic [7:0]  m_cnt;
  logic [2:0]  m_next;

  function automatic logic db_flip(input logic [15:0] h, input logic db);
    for (int i = 1; i <= DB; i++)
      if (h[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] model_step(input logic [1:0] st, input logic halt,
      input logic resume, input logic mode, input logic rise, input logic req);
    logic [1:0] want;
    want = mode ? 2'b01 : 2'b00;
    if (halt) return {2'b10, 1'b0};
    if (st == 2'b10) return resume ? {want, 1'b0} : {2'b10, 1'b0};
    if (st != want) return {want, 1'b0};
    return {st, mode ? req : rise};
  endfunction

  assign m_next = model_step(m_st, bus.halt, bus.resume, bus.mode,
                             hz_h[1] & ~hz_h[2], m_db_rose);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_h      <= '0;
      btn_h     <= '0;
      m_db      <= 1'b0;
      m_db_rose <= 1'b0;
      m_st      <= 2'b00;
      m_en      <= 1'b0;
      m_cnt     <= 8'd0;
    end else begin
      hz_h  <= {hz_h[2:0], bus.hz_in};
      btn_h <= {btn_h[14:0], bus.step_btn};
      if (db_flip(btn_h, m_db)) begin
        m_db      <= ~m_db;
        m_db_rose <= ~m_db;
      end else begin
        m_db_rose <= 1'b0;
      end
      m_st  <= m_next[2:1];
      m_en  <= m_next[0];
      m_cnt <= m_cnt + 8'(m_next[0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Advances n cycles; every negedge out of reset compares all outputs against the model.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!rst) begin
        chk("cycle", {bus.cpu_en, bus.state, bus.halted, bus.tick_count},
                     {m_en, m_st, (m_st == 2'b10), m_cnt});
        if (bus.cpu_en) pulses++;
      end
    end
  endtask

  task automatic press();
    bus.step_btn = 1'b1; cyc(10);
    bus.step_btn = 1'b0; cyc(10);
  endtask

  task automatic hz_periods(input int n, input int half);
    repeat (n) begin
      bus.hz_in = 1'b1; cyc(half);
      bus.hz_in = 1'b0; cyc(half);
    end
  endtask

  int base;

  initial begin
    bus.hz_in = 1'b0; bus.mode = 1'b0; bus.step_btn = 1'b0;
    bus.halt = 1'b0; bus.resume = 1'b0;
    cyc(3);
    chk("rst_cpu_en", bus.cpu_en, 1'b0);
    chk("rst_state", bus.state, 2'b00);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_tick", bus.tick_count, 8'd0);
    rst = 1'b0;
    cyc(2);

    // Run mode: 20 periods of 16 clk
    base = pulses;
    bus.hz_in = 1'b1; cyc(2);
    chk("run_lat_early", bus.cpu_en, 1'b0);
    cyc(1);
    chk("run_lat", bus.cpu_en, 1'b1);
    chk("run_first_tick", bus.tick_count, 8'd1);
    cyc(5);
    bus.hz_in = 1'b0; cyc(8);
    hz_periods(19, 8);
    chk("run_pulses", pulses - base, 20);
    chk("run_tick", bus.tick_count, 8'd20);

    // Bounce rejection in step mode
    bus.mode = 1'b1; cyc(2);
    chk("step_state", bus.state, 2'b01);
    base = pulses;
    for (int i = 0; i < 15; i++) begin bus.step_btn = (i % 2 == 0); cyc(2); end
    chk("bounce_none", pulses - base, 0);
    bus.step_btn = 1'b1; cyc(10);
    chk("press_one", pulses - base, 1);
    for (int i = 0; i < 15; i++) begin bus.step_btn = (i % 2 == 1); cyc(2); end
    bus.step_btn = 1'b0; cyc(10);
    chk("release_none", pulses - base, 1);

    // Halt beats a coincident hz_rise; halted state discards requests
    bus.mode = 1'b0; cyc(2);
    chk("back_to_run", bus.state, 2'b00);
    base = pulses;
    bus.hz_in = 1'b1; cyc(2);
    bus.halt = 1'b1; cyc(1);
    chk("halt_no_en", bus.cpu_en, 1'b0);
    chk("halt_state", bus.state, 2'b10);
    chk("halt_flag", bus.halted, 1'b1);
    bus.halt = 1'b0; cyc(3);
    bus.hz_in = 1'b0; cyc(4);
    hz_periods(3, 4);
    press();
    chk("halt_discard", pulses - base, 0);
    chk("halt_stays", bus.state, 2'b10);
    bus.resume = 1'b1; bus.halt = 1'b1; cyc(2);
    chk("resume_blocked", bus.state, 2'b10);
    bus.halt = 1'b0; cyc(1);
    bus.resume = 1'b0;
    chk("resume_run", bus.state, 2'b00);
    chk("resume_unhalted", bus.halted, 1'b0);
    bus.hz_in = 1'b1; cyc(3);
    chk("resume_strobe", bus.cpu_en, 1'b1);
    cyc(2); bus.hz_in = 1'b0; cyc(3);

    // Mode switch on the hz_rise edge
    bus.hz_in = 1'b1; cyc(2);
    bus.mode = 1'b1; cyc(1);
    chk("msw_state", bus.state, 2'b01);
    chk("msw_no_en", bus.cpu_en, 1'b0);
    base = pulses;
    cyc(3); bus.hz_in = 1'b0; cyc(4);
    hz_periods(2, 4);
    chk("msw_hz_ignored", pulses - base, 0);
    press();
    chk("msw_press", pulses - base, 1);
    bus.mode = 1'b0; cyc(2);

    // Wrap of tick_count after a fresh reset
    rst = 1'b1; cyc(1);
    rst = 1'b0; cyc(2);
    chk("wrap_start", bus.tick_count, 8'd0);
    for (int i = 1; i <= 256; i++) begin
      bus.hz_in = 1'b1; cyc(3);
      if (i == 255) chk("wrap_255", bus.tick_count, 8'd255);
      if (i == 256) chk("wrap_0", bus.tick_count, 8'd0);
      bus.hz_in = 1'b0; cyc(2);
    end

    // Reset while a strobe is live, hz_in left high through release
    for (int i = 1; i <= 7; i++) begin
      bus.hz_in = 1'b1; cyc(3);
      if (i < 7) begin bus.hz_in = 1'b0; cyc(2); end
    end
    chk("pre_rst_en", bus.cpu_en, 1'b1);
    chk("pre_rst_tick", bus.tick_count, 8'd7);
    #2 rst = 1'b1;
    #1;
    chk("midrst_en", bus.cpu_en, 1'b0);
    chk("midrst_state", bus.state, 2'b00);
    chk("midrst_halted", bus.halted, 1'b0);
    chk("midrst_tick", bus.tick_count, 8'd0);
    cyc(1);
    rst = 1'b0;
    base = pulses;
    cyc(2);
    chk("rel_early", bus.cpu_en, 1'b0);
    cyc(1);
    chk("rel_strobe", bus.cpu_en, 1'b1);
    chk("rel_tick", bus.tick_count, 8'd1);
    cyc(6);
    chk("rel_one", pulses - base, 1);
    bus.hz_in = 1'b0; cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
